// File: rtl/round_ctrl_pkg.sv
// Shared types and default parameters for the whack-a-mole round controller.
package round_ctrl_pkg;

    localparam int SCORE_W        = 7;
    localparam int CNT_W          = 5;
    localparam int ROUND_LEN_DEF  = 30;
    localparam int WARN_LEVEL_DEF = 5;
    localparam int SCORE_MAX_DEF  = 99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        OVER = 2'd3
    } state_e;

endpackage

// File: rtl/round_ctrl_count_sampler.sv
// Two-sample agreement filter for the slow-clock countdown value: the output
// only moves once two consecutive clk samples of the input match.
module count_sampler
    import round_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] count_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] sample1_q;
    logic [CNT_W-1:0] sample2_q;
    logic [CNT_W-1:0] count_q;

    // count_i is asynchronous; a value caught mid-transition never survives two samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample1_q <= '0;
            sample2_q <= '0;
            count_q   <= '0;
        end else begin
            sample1_q <= count_i;
            sample2_q <= sample1_q;
            if (sample1_q == sample2_q) begin
                count_q <= sample1_q;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/round_ctrl.sv
// Round controller: arms the countdown timer, runs the round, counts hits.
// Define ROUND_CTRL_HIGH_SCORE_EN to keep a best-score register.
module round_ctrl
    import round_ctrl_pkg::*;
#(
    parameter int ROUND_LEN  = ROUND_LEN_DEF,
    parameter int WARN_LEVEL = WARN_LEVEL_DEF,
    parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hit,
    input  logic [CNT_W-1:0]   count,
    output logic               timer_reset,
    output logic               active,
    output logic               over,
    output logic               warn,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score
);

    localparam logic [CNT_W-1:0]   ROUND_LEN_C  = CNT_W'(ROUND_LEN);
    localparam logic [CNT_W-1:0]   WARN_LEVEL_C = CNT_W'(WARN_LEVEL);
    localparam logic [SCORE_W-1:0] SCORE_MAX_C  = SCORE_W'(SCORE_MAX);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [CNT_W-1:0]   count_q;

    count_sampler u_sampler (
        .clk     (clk),
        .rst_n   (reset),
        .count_i (count),
        .count_o (count_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            score_q <= score_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        timer_reset = 1'b0;
        active      = 1'b0;
        over        = 1'b0;
        warn        = 1'b0;
        case (state_q)
            IDLE: begin
                timer_reset = 1'b1;
                if (start) begin
                    state_d = ARM;
                    score_d = '0;
                end
            end
            ARM: begin
                timer_reset = 1'b1;
                if (count_q == ROUND_LEN_C) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                active = 1'b1;
                warn   = (count_q <= WARN_LEVEL_C);
                // A hit on the final RUN cycle still counts.
                if (hit && (score_q < SCORE_MAX_C)) begin
                    score_d = score_q + SCORE_W'(1);
                end
                if (count_q == '0) begin
                    state_d = OVER;
                end
            end
            OVER: begin
                over = 1'b1;
                if (start) begin
                    state_d = ARM;
                    score_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign score = score_q;

`ifdef ROUND_CTRL_HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q;

    // Score is frozen in OVER, so the first OVER cycle's compare is final.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            high_q <= '0;
        end else if ((state_q == OVER) && (score_q > high_q)) begin
            high_q <= score_q;
        end
    end

    assign high_score = high_q;
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: stimulus queues expected outputs,
// a monitor pops and compares them on the falling edge (or on demand).
module tb_round_ctrl;
    import round_ctrl_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               hit;
    logic [CNT_W-1:0]   count;
    logic               timer_reset;
    logic               active;
    logic               over;
    logic               warn;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;

    round_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .hit         (hit),
        .count       (count),
        .timer_reset (timer_reset),
        .active      (active),
        .over        (over),
        .warn        (warn),
        .score       (score),
        .high_score  (high_score)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [17:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_score = 0;
    int   exp_high  = 0;
    event chk_ev;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic tr, input logic act,
                              input logic ov, input logic wn);
        exp_t e;
        e.name = name;
        e.exp  = {tr, act, ov, wn, 7'(exp_score), 7'(exp_high)};
        sb_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation against the live outputs.
    initial begin
        exp_t        e;
        logic [17:0] a;
        forever begin
            @(negedge clk or chk_ev);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                a = {timer_reset, active, over, warn, score, high_score};
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got tr=%b act=%b over=%b warn=%b score=%0d high=%0d, want tr=%b act=%b over=%b warn=%b score=%0d high=%0d",
                             e.name, a[17], a[16], a[15], a[14], a[13:7], a[6:0],
                             e.exp[17], e.exp[16], e.exp[15], e.exp[14], e.exp[13:7], e.exp[6:0]);
                end else begin
                    $display("check %s ok: score=%0d high=%0d", e.name, a[13:7], a[6:0]);
                end
            end
        end
    end

    task automatic pulse_hits(input int n);
        repeat (n) begin
            hit = 1'b1;
            if (exp_score < 99) exp_score++;
            tick();
            hit = 1'b0;
            tick();
        end
    endtask

    task automatic go_run(input string tag);
        start = 1'b1;
        exp_score = 0;
        tick();
        start = 1'b0;
        count = 5'd30;
        expect_out({tag, "_arm"}, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) tick();
        expect_out({tag, "_run"}, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic high_update();
`ifdef ROUND_CTRL_HIGH_SCORE_EN
        if (exp_score > exp_high) exp_high = exp_score;
`endif
    endtask

    task automatic end_round(input string tag);
        count = 5'd0;
        repeat (4) tick();
        expect_out({tag, "_over"}, 1'b0, 1'b0, 1'b1, 1'b0);
        high_update();
        tick();
        expect_out({tag, "_high"}, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int glitch[3];
        glitch = '{31, 0, 4};
        reset = 1'b0;
        start = 1'b0;
        hit   = 1'b0;
        count = 5'd30;
        repeat (2) tick();
        expect_out("reset_state", 1'b1, 1'b0, 1'b0, 1'b0);

        // Round 1: start right at reset release so ARM waits for the sampler.
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_out("r1_arm0", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("r1_arm1", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("r1_arm2", 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("r1_run", 1'b0, 1'b1, 1'b0, 1'b0);

        for (int v = 29; v >= 0; v--) begin
            count = 5'(v);
            for (int c = 0; c < 4; c++) begin
                hit   = (((v == 20) || (v == 3)) && (c == 0)) || ((v == 0) && (c == 3));
                start = (v == 15) && (c == 1);
                if (hit) exp_score++;
                tick();
                hit   = 1'b0;
                start = 1'b0;
            end
            if (v == 0)
                expect_out("r1_over", 1'b0, 1'b0, 1'b1, 1'b0);
            else
                expect_out($sformatf("r1_cnt%0d", v), 1'b0, 1'b1, 1'b0, (v <= 5));
        end
        high_update();
        tick();
        expect_out("r1_high", 1'b0, 1'b0, 1'b1, 1'b0);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        tick();
        expect_out("r1_over_hit_ignored", 1'b0, 1'b0, 1'b1, 1'b0);

        // Round 2: seven hits, then single-sample glitches on count.
        go_run("r2");
        count = 5'd12;
        repeat (4) tick();
        expect_out("r2_c12", 1'b0, 1'b1, 1'b0, 1'b0);
        pulse_hits(7);
        expect_out("r2_hits7", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) begin
            count = 5'(glitch[g]);
            tick();
            count = 5'd12;
            for (int k = 0; k < 4; k++) begin
                tick();
                expect_out($sformatf("r2_glitch%0d_t%0d", glitch[g], k), 1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
        end_round("r2");

        // Round 3: lower score must not replace the best score.
        go_run("r3");
        pulse_hits(4);
        end_round("r3");

        // Round 4: asynchronous reset mid-round.
        go_run("r4");
        pulse_hits(9);
        expect_out("r4_score9", 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        exp_score = 0;
        exp_high  = 0;
        #1;
        expect_out("r4_async_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        ->chk_ev;
        tick();
        expect_out("r4_reset_held", 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        expect_out("r5_idle", 1'b1, 1'b0, 1'b0, 1'b0);

        // Round 5: score saturation.
        go_run("r5");
        hit = 1'b1;
        repeat (105) begin
            if (exp_score < 99) exp_score++;
            tick();
        end
        hit = 1'b0;
        tick();
        expect_out("r5_sat99", 1'b0, 1'b1, 1'b0, 1'b0);
        end_round("r5");

        for (int i = 0; (i < 20) && (sb_q.size() > 0); i++) tick();
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
            errors += sb_q.size();
            checks += sb_q.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 ROUND_LEN, default 30: round length in seconds, the value the countdown timer reloads to.
REQ-002 WARN_LEVEL, default 5: remaining seconds at or below which the low-time warning asserts.
REQ-003 SCORE_MAX, default 99: score saturation value.
REQ-004 clk  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle start/restart request, clk domain.
REQ-007 hit  in  1  single-cycle successful-whack pulse, clk domain.
REQ-008 count  in  5  remaining seconds from the countdown timer; changes on the slow timer clock, asynchronous to clk.
REQ-009 timer_reset  out  1  high = timer held at/reloaded to ROUND_LEN.
REQ-010 active  out  1  round in progress.
REQ-011 over  out  1  round finished, score frozen.
REQ-012 warn  out  1  low-time warning.
REQ-013 score  out  7  current round score, unsigned binary.
REQ-014 high_score  out  7  best score since reset (see Configuration).

Function
REQ-015 Count sampling: internal count_q SHALL load count only when two consecutive clk samples of count are equal; otherwise count_q holds.
REQ-016 FSM states SHALL be IDLE, ARM, RUN, OVER.
REQ-017 IDLE: timer_reset=1, active=0, over=0; start -> ARM.
REQ-018 ARM: timer_reset=1; count_q==ROUND_LEN -> RUN; no timeout, waits indefinitely.
REQ-019 RUN: timer_reset=0, active=1; count_q==0 -> OVER.
REQ-020 OVER: timer_reset=0, over=1, score held; start -> ARM.
REQ-021 start in ARM or RUN SHALL be ignored.
REQ-022 On start accepted in IDLE or OVER, score SHALL clear to 0 on the same edge as the transition to ARM.
REQ-023 hit in RUN SHALL increment score by 1, saturating at SCORE_MAX; hit in any other state ignored.
REQ-024 hit on the same cycle RUN exits to OVER SHALL still be counted.
REQ-025 warn SHALL be 1 only while state==RUN and count_q<=WARN_LEVEL.
REQ-026 All outputs SHALL derive from registers only; no combinational input-to-output path.

Reset
REQ-027 Reset assertion SHALL take effect immediately, regardless of clk; deassertion is synchronised to clk by the integrating top level.
REQ-028 Reset values: state=IDLE, timer_reset=1, active=0, over=0, warn=0, score=0, high_score=0, count_q=0, sampler history=0.
REQ-029 Reset mid-round SHALL abandon the round with no residual state.

Configuration
REQ-030 Macro ROUND_CTRL_HIGH_SCORE_EN defined: high_score SHALL update to score on the cycle after entering OVER if score>high_score; cleared only by reset, never by start.
REQ-031 Macro undefined: high_score port SHALL remain present and be tied to 0, with no high-score register synthesised.

Structure
REQ-032 Package round_ctrl_pkg SHALL hold the state enum typedef, SCORE_W=7, and defaults for ROUND_LEN, WARN_LEVEL, and SCORE_MAX.
REQ-033 Sub-module count_sampler SHALL implement REQ-015: a 5-bit two-sample agreement filter with registered output.

Verification
REQ-034 Reset, then start with count held at 30 -> ARM for ≥2 cycles, RUN entered, timer_reset falls to 0, active=1.
REQ-035 In RUN, count steps 30..0 with 3 hits -> warn=1 from count 5, OVER at count 0, over=1, score=3.
REQ-036 105 hits in RUN -> score saturates at 99.
REQ-037 count glitches 12->31->12 on single samples -> count_q stays 12, no spurious transition.
REQ-038 Round with score 7, restart, round with score 4 -> with macro high_score=7; without macro high_score=0.
REQ-039 Reset asserted mid-RUN with score 9 -> all outputs take reset values immediately, without a clk edge.
